// File: rtl/pkg_write_controller_pkg.sv
// Shared types and default geometry for the packet write controller.
package pkg_write_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_NEXT  = 2'd2
  } wr_state_e;

  localparam int DEF_ADDR_WIDTH        = 8;
  localparam int DEF_ADDR_PAGE_NUM_LOG = 4;
  localparam int DEF_DATA_WIDTH        = 16;
  localparam int DEF_LEN_WIDTH         = 10;
  localparam int PAGE_OFS_W            = DEF_ADDR_WIDTH - DEF_ADDR_PAGE_NUM_LOG;

endpackage

// File: rtl/pkg_write_controller.sv
// Writes ingress packets into the paged buffer, chains pages, and issues one
// descriptor per packet. Also arbitrates the empty-table push port for page frees.
//
// state    | meaning
// ST_IDLE  | waiting for a packet, a free page and no pending descriptor
// ST_WRITE | accepting words into the current page
// ST_NEXT  | page full, waiting for the next free page to chain in
module pkg_write_controller
  import pkg_write_controller_pkg::*;
#(
  parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
  parameter int ADDR_PAGE_NUM_LOG = DEF_ADDR_PAGE_NUM_LOG,
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH         = DEF_LEN_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_last,
  output logic                         empty_table_read_req,
  input  logic [ADDR_PAGE_NUM_LOG-1:0] empty_table_read_addr,
  input  logic                         empty_table_empty,
  output logic                         empty_table_write_req,
  output logic [ADDR_PAGE_NUM_LOG-1:0] empty_table_write_addr,
  input  logic                         free_valid,
  output logic                         free_ready,
  input  logic [ADDR_PAGE_NUM_LOG-1:0] free_page,
  output logic                         ram_wr_en,
  output logic [ADDR_WIDTH-1:0]        ram_wr_addr,
  output logic [DATA_WIDTH-1:0]        ram_wr_data,
  output logic                         link_wr_en,
  output logic [ADDR_PAGE_NUM_LOG-1:0] link_wr_addr,
  output logic [ADDR_PAGE_NUM_LOG-1:0] link_wr_data,
  output logic                         desc_valid,
  input  logic                         desc_ready,
  output logic [ADDR_PAGE_NUM_LOG-1:0] desc_head,
  output logic [ADDR_PAGE_NUM_LOG-1:0] desc_tail,
  output logic [LEN_WIDTH-1:0]         desc_len
);

  localparam int OFS_W = ADDR_WIDTH - ADDR_PAGE_NUM_LOG;
  localparam logic [OFS_W-1:0]     OFS_LAST = '1;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX  = '1;

  wr_state_e                    state_q, state_d;
  logic [OFS_W-1:0]             offset_q, offset_d;
  logic [LEN_WIDTH-1:0]         len_q, len_d, len_inc;
  logic [ADDR_PAGE_NUM_LOG-1:0] head_q, head_d, cur_q, cur_d;
  logic                         desc_valid_q, desc_valid_d;
  logic [ADDR_PAGE_NUM_LOG-1:0] desc_head_q, desc_head_d, desc_tail_q, desc_tail_d;
  logic [LEN_WIDTH-1:0]         desc_len_q, desc_len_d;
  logic                         run_q;
  logic                         rd_req;

  assign len_inc = (len_q == LEN_MAX) ? len_q : len_q + LEN_WIDTH'(1);

  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    len_d        = len_q;
    head_d       = head_q;
    cur_d        = cur_q;
    desc_valid_d = desc_valid_q;
    desc_head_d  = desc_head_q;
    desc_tail_d  = desc_tail_q;
    desc_len_d   = desc_len_q;
    rd_req       = 1'b0;
    in_ready     = 1'b0;
    ram_wr_en    = 1'b0;
    link_wr_en   = 1'b0;

    if (desc_valid_q && desc_ready) desc_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run_q && in_valid && !empty_table_empty && !desc_valid_q) begin
          rd_req   = 1'b1;
          head_d   = empty_table_read_addr;
          cur_d    = empty_table_read_addr;
          offset_d = '0;
          len_d    = '0;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ram_wr_en = 1'b1;
          offset_d  = offset_q + OFS_W'(1);
          len_d     = len_inc;
          if (in_last) begin
            // Last word on the final slot still ends here: no spare page is popped.
            desc_valid_d = 1'b1;
            desc_head_d  = head_q;
            desc_tail_d  = cur_q;
            desc_len_d   = len_inc;
            state_d      = ST_IDLE;
          end else if (offset_q == OFS_LAST) begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        if (!empty_table_empty) begin
          rd_req     = 1'b1;
          link_wr_en = 1'b1;
          cur_d      = empty_table_read_addr;
          offset_d   = '0;
          state_d    = ST_WRITE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Allocation owns the manager port; a free is only accepted when no pop is issued.
  assign empty_table_read_req   = rd_req;
  assign free_ready             = run_q & ~rd_req;
  assign empty_table_write_req  = free_valid & free_ready;
  assign empty_table_write_addr = free_page;

  assign ram_wr_addr  = {cur_q, offset_q};
  assign ram_wr_data  = in_data;
  assign link_wr_addr = cur_q;
  assign link_wr_data = empty_table_read_addr;
  assign desc_valid   = desc_valid_q;
  assign desc_head    = desc_head_q;
  assign desc_tail    = desc_tail_q;
  assign desc_len     = desc_len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      offset_q     <= '0;
      len_q        <= '0;
      head_q       <= '0;
      cur_q        <= '0;
      desc_valid_q <= 1'b0;
      desc_head_q  <= '0;
      desc_tail_q  <= '0;
      desc_len_q   <= '0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      len_q        <= len_d;
      head_q       <= head_d;
      cur_q        <= cur_d;
      desc_valid_q <= desc_valid_d;
      desc_head_q  <= desc_head_d;
      desc_tail_q  <= desc_tail_d;
      desc_len_q   <= desc_len_d;
      run_q        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pkg_write_controller.sv
// Directed bench for pkg_write_controller with a small empty-table model.
module tb_pkg_write_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [15:0] in_data = '0;
  logic        rd_req, et_empty, wr_req;
  logic [3:0]  et_addr, wr_addr;
  logic        free_valid = 1'b0, free_ready;
  logic [3:0]  free_page = '0;
  logic        ram_wr_en, link_wr_en;
  logic [7:0]  ram_wr_addr;
  logic [15:0] ram_wr_data;
  logic [3:0]  link_wr_addr, link_wr_data;
  logic        desc_valid, desc_ready = 1'b1;
  logic [3:0]  desc_head, desc_tail;
  logic [9:0]  desc_len;

  always #5 clk = ~clk;

  pkg_write_controller dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .empty_table_read_req(rd_req), .empty_table_read_addr(et_addr),
    .empty_table_empty(et_empty),
    .empty_table_write_req(wr_req), .empty_table_write_addr(wr_addr),
    .free_valid(free_valid), .free_ready(free_ready), .free_page(free_page),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .link_wr_en(link_wr_en), .link_wr_addr(link_wr_addr), .link_wr_data(link_wr_data),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_head(desc_head), .desc_tail(desc_tail), .desc_len(desc_len)
  );

  // Empty-table model: ring of pushed pages, popped one edge after read_req is seen.
  logic [3:0] pg_mem [16];
  int n_pushed = 0;
  int pops = 0;
  int rd_total = 0;
  int collisions = 0;
  assign et_empty = (n_pushed == pops);
  assign et_addr  = pg_mem[pops[3:0]];

  always @(posedge clk) pops <= rd_total;

  logic [23:0] ram_log [$];
  logic [7:0]  link_log [$];
  logic [17:0] desc_log [$];

  always @(negedge clk) begin
    if (rd_req) rd_total = rd_total + 1;
    if (rd_req && wr_req) collisions = collisions + 1;
    if (ram_wr_en) ram_log.push_back({ram_wr_addr, ram_wr_data});
    if (link_wr_en) link_log.push_back({link_wr_addr, link_wr_data});
    if (desc_valid && desc_ready) desc_log.push_back({desc_head, desc_tail, desc_len});
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_page(input logic [3:0] p);
    pg_mem[n_pushed[3:0]] = p;
    n_pushed = n_pushed + 1;
  endtask

  // Called in the posedge+1 phase; returns in the same phase after the word is taken.
  task automatic send_word(input logic [15:0] d, input logic last);
    int  t;
    logic acc;
    t = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) chk("send_word_timeout", 32'(d), 32'hFFFF_FFFF);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_desc(input int d0);
    int t;
    t = 0;
    while (desc_log.size() <= d0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    if (desc_log.size() <= d0) chk("desc_timeout", 32'(t), 32'd0);
  endtask

  typedef struct {
    int         n;
    logic [3:0] pg0;
    logic [3:0] pg1;
    logic [3:0] head;
    logic [3:0] tail;
    int         len;
    int         rds;
    int         links;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int r0, l0, d0, rd0, bad;
    logic [3:0]  pg;
    logic [15:0] dat;

    vecs[0] = '{n: 3,  pg0: 4'd5,  pg1: 4'd0, head: 4'd5,  tail: 4'd5,  len: 3,  rds: 1, links: 0};
    vecs[1] = '{n: 20, pg0: 4'd2,  pg1: 4'd7, head: 4'd2,  tail: 4'd7,  len: 20, rds: 2, links: 1};
    vecs[2] = '{n: 16, pg0: 4'd11, pg1: 4'd0, head: 4'd11, tail: 4'd11, len: 16, rds: 1, links: 0};
    vecs[3] = '{n: 1,  pg0: 4'd0,  pg1: 4'd0, head: 4'd0,  tail: 4'd0,  len: 1,  rds: 1, links: 0};
    vecs[4] = '{n: 17, pg0: 4'd3,  pg1: 4'd4, head: 4'd3,  tail: 4'd4,  len: 17, rds: 2, links: 1};

    // Reset: a pending free must not be accepted while in reset.
    free_valid = 1'b1;
    free_page  = 4'd3;
    #12;
    chk("reset_strobes", 32'({in_ready, rd_req, wr_req, free_ready, desc_valid, ram_wr_en, link_wr_en}), 32'd0);
    chk("reset_desc", 32'({desc_head, desc_tail, desc_len}), 32'd0);
    free_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle free: accepted the same cycle.
    free_valid = 1'b1;
    free_page  = 4'd4;
    @(negedge clk);
    chk("idle_free", 32'({free_ready, wr_req, wr_addr}), 32'({1'b1, 1'b1, 4'd4}));
    @(posedge clk);
    #1;
    free_valid = 1'b0;

    for (int v = 0; v < 5; v++) begin
      push_page(vecs[v].pg0);
      if (vecs[v].rds == 2) push_page(vecs[v].pg1);
      r0 = ram_log.size(); l0 = link_log.size(); d0 = desc_log.size(); rd0 = rd_total;
      for (int i = 0; i < vecs[v].n; i++)
        send_word(16'hA000 + 16'(v * 256 + i), (i == vecs[v].n - 1));
      wait_desc(d0);
      if (desc_log.size() > d0)
        chk($sformatf("v%0d_desc", v), 32'(desc_log[d0]),
            32'({vecs[v].head, vecs[v].tail, 10'(vecs[v].len)}));
      chk($sformatf("v%0d_reads", v), 32'(rd_total - rd0), 32'(vecs[v].rds));
      chk($sformatf("v%0d_links", v), 32'(link_log.size() - l0), 32'(vecs[v].links));
      if (vecs[v].links == 1 && link_log.size() > l0)
        chk($sformatf("v%0d_link_val", v), 32'(link_log[l0]), 32'({vecs[v].pg0, vecs[v].pg1}));
      chk($sformatf("v%0d_nwords", v), 32'(ram_log.size() - r0), 32'(vecs[v].n));
      if (ram_log.size() - r0 == vecs[v].n) begin
        for (int i = 0; i < vecs[v].n; i++) begin
          pg  = (i < 16) ? vecs[v].pg0 : vecs[v].pg1;
          dat = 16'hA000 + 16'(v * 256 + i);
          chk($sformatf("v%0d_w%0d", v, i), 32'(ram_log[r0 + i]), 32'({pg, 4'(i % 16), dat}));
        end
      end
    end

    // Empty table while the packet needs a second page: hold off for 10 cycles.
    push_page(4'd6);
    r0 = ram_log.size(); l0 = link_log.size(); d0 = desc_log.size();
    for (int i = 0; i < 16; i++) send_word(16'hB000 + 16'(i), 1'b0);
    in_valid = 1'b1;
    in_data  = 16'hB010;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || ram_wr_en !== 1'b0 || rd_req !== 1'b0) bad++;
    end
    chk("stall_backpressure", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    push_page(4'd12);
    send_word(16'hB010, 1'b0);
    send_word(16'hB011, 1'b1);
    wait_desc(d0);
    if (desc_log.size() > d0) chk("stall_desc", 32'(desc_log[d0]), 32'({4'd6, 4'd12, 10'd18}));
    if (ram_log.size() >= r0 + 18) begin
      chk("stall_w16", 32'(ram_log[r0 + 16]), 32'({8'hC0, 16'hB010}));
      chk("stall_w17", 32'(ram_log[r0 + 17]), 32'({8'hC1, 16'hB011}));
    end else chk("stall_nwords", 32'(ram_log.size() - r0), 32'd18);
    if (link_log.size() > l0) chk("stall_link", 32'(link_log[l0]), 32'({4'd6, 4'd12}));
    else chk("stall_link_cnt", 32'(link_log.size() - l0), 32'd1);

    // Free arriving in the same cycle as the NEXT allocation.
    push_page(4'd1);
    d0 = desc_log.size(); l0 = link_log.size();
    for (int i = 0; i < 16; i++) send_word(16'hC000 + 16'(i), 1'b0);
    push_page(4'd8);
    free_valid = 1'b1;
    free_page  = 4'd9;
    @(negedge clk);
    chk("alloc_cycle", 32'({rd_req, free_ready, wr_req}), 32'({1'b1, 1'b0, 1'b0}));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("free_after_alloc", 32'({free_ready, wr_req, wr_addr}), 32'({1'b1, 1'b1, 4'd9}));
    @(posedge clk);
    #1;
    free_valid = 1'b0;
    send_word(16'hC010, 1'b1);
    wait_desc(d0);
    if (desc_log.size() > d0) chk("free_desc", 32'(desc_log[d0]), 32'({4'd1, 4'd8, 10'd17}));
    if (link_log.size() > l0) chk("free_link", 32'(link_log[l0]), 32'({4'd1, 4'd8}));
    else chk("free_link_cnt", 32'(link_log.size() - l0), 32'd1);

    // Descriptor back-pressure blocks the next packet.
    desc_ready = 1'b0;
    push_page(4'd13);
    push_page(4'd14);
    for (int i = 0; i < 3; i++) send_word(16'hD000 + 16'(i), (i == 2));
    in_valid = 1'b1;
    in_data  = 16'hD100;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (desc_valid !== 1'b1 || {desc_head, desc_tail, desc_len} !== {4'd13, 4'd13, 10'd3} ||
          rd_req !== 1'b0 || in_ready !== 1'b0) bad++;
    end
    chk("desc_hold", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    desc_ready = 1'b1;
    @(negedge clk);
    chk("desc_handshake", 32'({desc_valid, rd_req}), 32'({1'b1, 1'b0}));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("restart_read_req", 32'({desc_valid, rd_req}), 32'({1'b0, 1'b1}));
    @(posedge clk);
    #1;
    d0 = desc_log.size();
    r0 = ram_log.size();
    send_word(16'hD100, 1'b0);
    send_word(16'hD101, 1'b1);
    wait_desc(d0);
    if (desc_log.size() > d0) chk("second_desc", 32'(desc_log[d0]), 32'({4'd14, 4'd14, 10'd2}));
    if (ram_log.size() > r0) chk("second_w0", 32'(ram_log[r0]), 32'({8'hE0, 16'hD100}));

    chk("no_req_collision", 32'(collisions), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
